// File: rtl/vx_smem_banked_pkg.sv
// Shared definitions for the banked shared-memory unit: FSM states and
// helpers for the address split into bank select and bank row.
package vx_smem_banked_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE,
    ST_DRAIN,
    ST_RESP
  } state_t;

  localparam int DCORE_TAG_WIDTH = 8;
  localparam int BYTE_W          = 8;

  function automatic int bank_sel_bits(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int bank_depth(input int size, input int word_size, input int num_banks);
    return size / (word_size * num_banks);
  endfunction

  function automatic int row_bits(input int size, input int word_size, input int num_banks);
    return $clog2(size / (word_size * num_banks));
  endfunction

  // Derived widths for the default configuration (4 banks, 4-byte words, 16 KiB).
  localparam int DEF_BANK_SEL_BITS = bank_sel_bits(4);
  localparam int DEF_BANK_DEPTH    = bank_depth(16384, 4, 4);
  localparam int DEF_ROW_BITS      = row_bits(16384, 4, 4);

endpackage

// File: rtl/vx_smem_banked_sp_ram.sv
// Single-port SRAM bank: synchronous read with one-cycle latency, byte-enabled
// write. Contents are intentionally not reset.
module VX_sp_ram
  import vx_smem_banked_pkg::*;
#(
  parameter int DATAW   = 32,
  parameter int DEPTH   = 1024,
  parameter int BYTEENW = DATAW / BYTE_W,
  parameter int ADDRW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [BYTEENW-1:0] byteen,
  input  logic [ADDRW-1:0]   addr,
  input  logic [DATAW-1:0]   wdata,
  output logic [DATAW-1:0]   rdata
);

  logic [DATAW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BYTEENW; i++) begin
          if (byteen[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/vx_smem_banked.sv
// Banked shared memory: accepts one lane batch, serializes same-bank lanes in
// ascending lane order, then returns one gathered read response with the tag.
module vx_smem_banked
  import vx_smem_banked_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 4,
  parameter int WORD_SIZE = 4,
  parameter int SIZE      = 16384,
  parameter int TAG_WIDTH = DCORE_TAG_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  input  logic [NUM_REQS-1:0]             req_rw,
  input  logic [NUM_REQS*WORD_SIZE-1:0]   req_byteen,
  input  logic [NUM_REQS*(32-$clog2(WORD_SIZE))-1:0] req_addr,
  input  logic [NUM_REQS*WORD_SIZE*8-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]            req_tag,
  output logic                            req_ready,
  output logic [NUM_REQS-1:0]             rsp_valid,
  output logic [NUM_REQS*WORD_SIZE*8-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]            rsp_tag,
  input  logic                            rsp_ready
);

  localparam int AW    = 32 - $clog2(WORD_SIZE);
  localparam int DW    = WORD_SIZE * 8;
  localparam int BB    = bank_sel_bits(NUM_BANKS);
  localparam int RB    = row_bits(SIZE, WORD_SIZE, NUM_BANKS);
  localparam int DEPTH = bank_depth(SIZE, WORD_SIZE, NUM_BANKS);
  localparam int LW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  state_t state_reg, state_next;
  logic [NUM_REQS-1:0] pending_reg, pending_next;
  logic [NUM_REQS-1:0] rdmask_reg, rdmask_next;
  logic                accept;

  logic [BB-1:0]        bank_reg   [NUM_REQS];
  logic [RB-1:0]        row_reg    [NUM_REQS];
  logic [WORD_SIZE-1:0] byteen_reg [NUM_REQS];
  logic [DW-1:0]        wdata_reg  [NUM_REQS];
  logic [DW-1:0]        lane_data_reg [NUM_REQS];
  logic [NUM_REQS-1:0]  rw_reg;
  logic [TAG_WIDTH-1:0] tag_reg;

  logic [NUM_REQS-1:0]  grant_mat  [NUM_BANKS];
  logic [NUM_REQS-1:0]  granted_lanes;
  logic [NUM_BANKS-1:0] rd_issue;
  logic [LW-1:0]        rd_lane    [NUM_BANKS];
  logic [DW-1:0]        bank_rdata [NUM_BANKS];
  logic [NUM_BANKS-1:0] rd_vld_reg;
  logic [LW-1:0]        rd_lane_reg [NUM_BANKS];

  // Address bits above bank+row are ignored so addresses wrap modulo SIZE.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  assign req_ready = (state_reg == ST_IDLE) && !reset;
  assign rsp_valid = (state_reg == ST_RESP) ? rdmask_reg : '0;
  assign rsp_tag   = tag_reg;

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_lane_out
    assign rsp_data[gi*DW +: DW] = lane_data_reg[gi];
  end

  // Per-bank priority encoder: lowest pending lane mapped to the bank wins.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [NUM_REQS-1:0] gvec;
    logic [LW-1:0]       glane;
    logic                gany;

    always_comb begin
      gvec  = '0;
      glane = '0;
      gany  = 1'b0;
      for (int l = 0; l < NUM_REQS; l++) begin
        if (!gany && pending_reg[l] && (bank_reg[l] == BB'(gi))) begin
          gvec[l] = 1'b1;
          glane   = LW'(l);
          gany    = 1'b1;
        end
      end
    end

    assign grant_mat[gi] = gvec;
    assign rd_issue[gi]  = gany & ~rw_reg[glane];
    assign rd_lane[gi]   = glane;

    VX_sp_ram #(
      .DATAW   (DW),
      .DEPTH   (DEPTH),
      .BYTEENW (WORD_SIZE)
    ) u_bank (
      .clk    (clk),
      .en     (gany),
      .we     (rw_reg[glane]),
      .byteen (byteen_reg[glane]),
      .addr   (row_reg[glane]),
      .wdata  (wdata_reg[glane]),
      .rdata  (bank_rdata[gi])
    );
  end

  always_comb begin
    granted_lanes = '0;
    for (int b = 0; b < NUM_BANKS; b++) granted_lanes = granted_lanes | grant_mat[b];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      pending_reg <= '0;
      rdmask_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      rdmask_reg  <= rdmask_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    rdmask_next  = rdmask_reg;
    accept       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|req_valid) begin
          accept       = 1'b1;
          pending_next = req_valid;
          rdmask_next  = req_valid & ~req_rw;
          state_next   = ST_SERVE;
        end
      end
      ST_SERVE: begin
        pending_next = pending_reg & ~granted_lanes;
        if (pending_next == '0) state_next = (rdmask_reg != '0) ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: state_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Read data lands one cycle after issue; route it to the lane that issued it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_reg     <= '0;
      tag_reg    <= '0;
      rd_vld_reg <= '0;
      for (int l = 0; l < NUM_REQS; l++) begin
        bank_reg[l]      <= '0;
        row_reg[l]       <= '0;
        byteen_reg[l]    <= '0;
        wdata_reg[l]     <= '0;
        lane_data_reg[l] <= '0;
      end
      for (int b = 0; b < NUM_BANKS; b++) rd_lane_reg[b] <= '0;
    end else begin
      if (accept) begin
        rw_reg  <= req_rw;
        tag_reg <= req_tag;
        for (int l = 0; l < NUM_REQS; l++) begin
          bank_reg[l]   <= req_addr[l*AW +: BB];
          row_reg[l]    <= req_addr[l*AW + BB +: RB];
          byteen_reg[l] <= req_byteen[l*WORD_SIZE +: WORD_SIZE];
          wdata_reg[l]  <= req_data[l*DW +: DW];
        end
      end
      rd_vld_reg <= rd_issue;
      for (int b = 0; b < NUM_BANKS; b++) begin
        rd_lane_reg[b] <= rd_lane[b];
        if (rd_vld_reg[b]) lane_data_reg[rd_lane_reg[b]] <= bank_rdata[b];
      end
    end
  end

endmodule

// File: doc/vx_smem_banked.md
# vx_smem_banked

Banked shared-memory unit that consumes the shared-memory request stream produced by the data-bus arbiter and returns per-lane read data on the shared-memory response stream. It accepts one wavefront batch at a time, sorts the active lanes onto `NUM_BANKS` single-port SRAM banks and serializes bank conflicts over successive cycles. It then returns a single gathered response carrying the batch tag. It sits between the data-bus arbiter (upstream, request side) and the arbiter's response stream (downstream).

## Interface
- `NUM_REQS`, 4: lanes per batch; must equal `NUM_THREADS`.
- `NUM_BANKS`, 4: SRAM banks; power of two, ≤ `NUM_REQS`.
- `WORD_SIZE`, 4: bytes per word.
- `SIZE`, 16384: total bytes; power of two.
- `TAG_WIDTH`, `DCORE_TAG_WIDTH`: request/response tag width.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in `NUM_REQS`: per-lane request valid; the batch is the set of lanes that are set.
- `req_rw` in `NUM_REQS`: 1 = write, 0 = read.
- `req_byteen` in `NUM_REQS*WORD_SIZE`: per-lane write byte enables.
- `req_addr` in `NUM_REQS*(32-log2(WORD_SIZE))`: per-lane word address.
- `req_data` in `NUM_REQS*WORD_SIZE*8`: per-lane write data.
- `req_tag` in `TAG_WIDTH`: batch tag.
- `req_ready` out 1: batch accepted when `|req_valid && req_ready`.
- `rsp_valid` out `NUM_REQS`: lanes of the accepted batch that were reads.
- `rsp_data` out `NUM_REQS*WORD_SIZE*8`: per-lane read data.
- `rsp_tag` out `TAG_WIDTH`: tag of the batch being answered.
- `rsp_ready` in 1: downstream accepts the response.

## Operation
- Bank index is `addr[log2(NUM_BANKS)-1:0]`. Row is the next `log2(SIZE/(WORD_SIZE*NUM_BANKS))` bits. Higher address bits are ignored, so addresses wrap modulo `SIZE`.
- Four states, with these transitions:
  - IDLE: `req_ready` = 1 (forced to 0 while `reset` is high). On handshake, latch addr, rw, byteen, data and tag for every lane. Set `pending` = `req_valid` and `rdmask` = `req_valid & ~req_rw`. Go to SERVE.
  - SERVE: for each bank, grant the lowest-index pending lane that maps to it. Granted writes update the bank in that cycle under byteen. Granted reads issue that cycle. Clear granted bits from `pending`. When `pending` becomes empty, go to DRAIN if `rdmask` ≠ 0, otherwise go to IDLE.
  - DRAIN: one cycle. Bank read data from the last grant cycle is captured into the per-lane data registers. Go to RESP.
  - RESP: `rsp_valid` = `rdmask`; `rsp_data` and `rsp_tag` are held stable. On `rsp_ready`, go to IDLE.
- Read data from each grant cycle is captured into the granted lane's register on the following cycle. This happens whether that cycle is SERVE or DRAIN.
- Same-bank conflicts are served in ascending lane order. A write in a lower lane is visible to a later-served read of the same address in the same batch.
- Same-bank lanes are never merged, even when their addresses are identical.
- A batch containing only writes produces no response.
- SRAM contents are not reset.

## Timing
- Reset values: state IDLE, `pending` 0, `rdmask` 0, `rsp_valid` 0, `rsp_tag` 0, `rsp_data` 0. `req_ready` is 0 during reset and 1 in the first cycle after release.
- Let K be the maximum number of batch lanes that map to one bank.
- With acceptance in cycle 0: SERVE occupies cycles 1..K, DRAIN is cycle K+1, and `rsp_valid` first rises in cycle K+2. Conflict-free latency is 3.
- For a write-only batch, `req_ready` rises again in cycle K+1.
- Throughput: one batch in flight. The next batch is accepted no earlier than the cycle after the response handshake.
- `rsp_*` may not change while `rsp_valid` ≠ 0 and `rsp_ready` = 0.
- Reset mid-operation (any state): the batch is dropped and no response is issued. Writes already granted remain in the SRAM.

## Structure
- Shared package holds:
  - the state enum (IDLE, SERVE, DRAIN, RESP);
  - derived widths: bank-select bits, row bits, bank depth = `SIZE/(WORD_SIZE*NUM_BANKS)`.
- One sub-module: `VX_sp_ram`, instantiated `NUM_BANKS` times.
  - Single-port, synchronous read with 1-cycle latency.
  - Byte-enabled write.
- Lane-to-bank grant logic is a per-bank priority encoder over `pending` and stays in this module.

## Test plan
- **Conflict-free read:** preload words 0x100..0x103. Read lanes 0–3 with tag 0x2A. Expect `rsp_valid`=1111 in cycle 3, data in lane order, `rsp_tag`=0x2A.
- **4-way conflict:** read lanes at addresses 0, 4, 8, 12 (all bank 0). Expect SERVE for 4 cycles, `rsp_valid`=1111 in cycle 6, correct data per lane.
- **Partial write:** word 5 = 0x11223344. Write 0xAABBCCDD with byteen 0011; expect no response and `req_ready` back in cycle 2. Then read word 5; expect 0x1122CCDD.
- **Intra-batch ordering:** lane 0 writes 0xDEADBEEF to address 9 and lane 1 reads address 9 in the same batch. Expect `rsp_valid`=0010 and lane 1 data 0xDEADBEEF.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles. Expect `rsp_*` stable and `req_ready`=0 throughout; after the handshake, `req_ready`=1 the next cycle.
- **Reset during SERVE:** assert `reset` during SERVE of a conflicting batch. Expect `rsp_valid` never rises and `req_ready`=1 in the first cycle after release.
